// File: rtl/player_input_ctrl.sv
// player_input_ctrl: turns raw board buttons into clean one-cycle command
// strobes (start/left/right/shoot). Each button is synchronised and
// debounced, and press edges are extracted. A held direction auto-repeats,
// and the fire button has a cooldown. All outputs are registered.
module player_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 8,
    parameter int SHOOT_COOLDOWN  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_shoot,
    input  logic play,
    output logic start,
    output logic left,
    output logic right,
    output logic shoot,
    output logic shoot_ready
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    localparam int CD_W = $clog2(SHOOT_COOLDOWN + 1);

    // The counter value at which the next mismatching cycle completes the
    // stable window, so the level flips at that edge.
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(SHOOT_COOLDOWN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_L   = 2'd1,
        HOLD_R   = 2'd2,
        CONFLICT = 2'd3
    } dir_state_t;

    // Bit order: 0 = start, 1 = left, 2 = right, 3 = shoot.
    logic [3:0] btn_raw;
    logic [3:0] db_lvl;
    logic [3:0] press;

    assign btn_raw = {btn_shoot, btn_right, btn_left, btn_start};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic            s1_reg;
            logic            s2_reg;
            logic            db_reg;
            logic            db_prev_reg;
            logic [DB_W-1:0] cnt_reg;

            // Two-flop synchroniser followed by a stable-window debouncer.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s1_reg      <= 1'b0;
                    s2_reg      <= 1'b0;
                    db_reg      <= 1'b0;
                    db_prev_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    s1_reg      <= btn_raw[gi];
                    s2_reg      <= s1_reg;
                    db_prev_reg <= db_reg;
                    if (s2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        db_reg  <= s2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign db_lvl[gi] = db_reg;
            assign press[gi]  = db_reg & ~db_prev_reg;
        end
    endgenerate

    // Start/shoot only need press edges; left/right only need levels.
    logic unused_ok;
    assign unused_ok = &{1'b0, db_lvl[0], db_lvl[3], press[1], press[2]};

    logic            start_reg;
    logic            left_reg;
    logic            right_reg;
    logic            shoot_reg;
    logic            ready_reg;
    dir_state_t      dir_state_reg;
    logic [RP_W-1:0] rpt_reg;
    logic [CD_W-1:0] cd_reg;

    // Start is only meaningful from the title screen; presses in game are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_reg <= 1'b0;
        end else begin
            start_reg <= press[0] & ~play;
        end
    end

    // Direction FSM: first strobe on entry, then one every REPEAT_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_state_reg <= IDLE;
            rpt_reg       <= '0;
            left_reg      <= 1'b0;
            right_reg     <= 1'b0;
        end else begin
            left_reg  <= 1'b0;
            right_reg <= 1'b0;
            if (!play) begin
                dir_state_reg <= IDLE;
                rpt_reg       <= '0;
            end else begin
                case (dir_state_reg)
                    IDLE: begin
                        if (db_lvl[1] && !db_lvl[2]) begin
                            left_reg      <= 1'b1;
                            rpt_reg       <= RP_RELOAD;
                            dir_state_reg <= HOLD_L;
                        end else if (db_lvl[2] && !db_lvl[1]) begin
                            right_reg     <= 1'b1;
                            rpt_reg       <= RP_RELOAD;
                            dir_state_reg <= HOLD_R;
                        end else if (db_lvl[1] && db_lvl[2]) begin
                            dir_state_reg <= CONFLICT;
                        end
                    end
                    HOLD_L: begin
                        if (!db_lvl[1]) begin
                            dir_state_reg <= IDLE;
                        end else if (db_lvl[2]) begin
                            dir_state_reg <= CONFLICT;
                        end else if (rpt_reg == '0) begin
                            left_reg <= 1'b1;
                            rpt_reg  <= RP_RELOAD;
                        end else begin
                            rpt_reg <= rpt_reg - 1'b1;
                        end
                    end
                    HOLD_R: begin
                        if (!db_lvl[2]) begin
                            dir_state_reg <= IDLE;
                        end else if (db_lvl[1]) begin
                            dir_state_reg <= CONFLICT;
                        end else if (rpt_reg == '0) begin
                            right_reg <= 1'b1;
                            rpt_reg   <= RP_RELOAD;
                        end else begin
                            rpt_reg <= rpt_reg - 1'b1;
                        end
                    end
                    CONFLICT: begin
                        // Wait until the player resolves the conflict; the
                        // IDLE rules then issue any strobe on the next cycle.
                        if (!(db_lvl[1] && db_lvl[2])) begin
                            dir_state_reg <= IDLE;
                        end
                    end
                    default: dir_state_reg <= IDLE;
                endcase
            end
        end
    end

    // Fire with cooldown; ready is registered from the next cooldown value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cd_reg    <= '0;
            shoot_reg <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            shoot_reg <= 1'b0;
            if (!play) begin
                cd_reg    <= '0;
                ready_reg <= 1'b1;
            end else if (press[3] && (cd_reg == '0)) begin
                shoot_reg <= 1'b1;
                cd_reg    <= CD_LOAD;
                ready_reg <= 1'b0;
            end else if (cd_reg != '0) begin
                cd_reg    <= cd_reg - 1'b1;
                ready_reg <= (cd_reg == CD_W'(1));
            end else begin
                ready_reg <= 1'b1;
            end
        end
    end

    assign start       = start_reg;
    assign left        = left_reg;
    assign right       = right_reg;
    assign shoot       = shoot_reg;
    assign shoot_ready = ready_reg;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: an edge-level behavioural model checked on
// every falling edge, plus directed scenarios with literal timing checks.
module tb_player_input_ctrl;

    localparam int DB  = 4;
    localparam int REP = 8;
    localparam int CD  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_start = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_shoot = 1'b0;
    logic play = 1'b0;
    logic start, left, right, shoot, shoot_ready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES(REP),
        .SHOOT_COOLDOWN(CD)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .btn_start(btn_start),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_shoot(btn_shoot),
        .play(play),
        .start(start),
        .left(left),
        .right(right),
        .shoot(shoot),
        .shoot_ready(shoot_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per button: the raw level reaches the debouncer two edges late, and
    // the clean level follows it after DB consecutive disagreeing cycles.
    bit pipe_a[4], pipe_b[4], lvl[4], lvl_prev[4], pr[4];
    int disagree[4];
    int mode = 0;          // 0 none, 1 left held, 2 right held, 3 both held
    int age = 0;           // cycles since the direction was first issued
    int since_shot = CD;   // cycles since last accepted shot (saturating)
    bit m_start = 0, m_left = 0, m_right = 0, m_shoot = 0, m_ready = 1;
    bit raw[4];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int b = 0; b < 4; b++) begin
                    pipe_a[b] = 0; pipe_b[b] = 0; lvl[b] = 0; lvl_prev[b] = 0;
                    disagree[b] = 0;
                end
                mode = 0; age = 0; since_shot = CD;
                m_start = 0; m_left = 0; m_right = 0; m_shoot = 0; m_ready = 1;
            end else begin
                raw[0] = btn_start; raw[1] = btn_left; raw[2] = btn_right; raw[3] = btn_shoot;
                for (int b = 0; b < 4; b++) pr[b] = lvl[b] && !lvl_prev[b];
                m_start = pr[0] && !play;
                m_left = 0; m_right = 0;
                if (!play) begin
                    mode = 0;
                end else begin
                    case (mode)
                        0: begin
                            if (lvl[1] && !lvl[2]) begin mode = 1; age = 0; m_left = 1; end
                            else if (lvl[2] && !lvl[1]) begin mode = 2; age = 0; m_right = 1; end
                            else if (lvl[1] && lvl[2]) mode = 3;
                        end
                        1: begin
                            if (!lvl[1]) mode = 0;
                            else if (lvl[2]) mode = 3;
                            else begin age++; if (age % REP == 0) m_left = 1; end
                        end
                        2: begin
                            if (!lvl[2]) mode = 0;
                            else if (lvl[1]) mode = 3;
                            else begin age++; if (age % REP == 0) m_right = 1; end
                        end
                        default: if (!(lvl[1] && lvl[2])) mode = 0;
                    endcase
                end
                m_shoot = 0;
                if (!play) since_shot = CD;
                else if (pr[3] && since_shot >= CD) begin m_shoot = 1; since_shot = 0; end
                else if (since_shot < CD) since_shot++;
                m_ready = (since_shot >= CD);
                for (int b = 0; b < 4; b++) begin
                    lvl_prev[b] = lvl[b];
                    if (pipe_b[b] == lvl[b]) disagree[b] = 0;
                    else begin
                        disagree[b]++;
                        if (disagree[b] == DB) begin lvl[b] = pipe_b[b]; disagree[b] = 0; end
                    end
                    pipe_b[b] = pipe_a[b];
                    pipe_a[b] = raw[b];
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("start", int'(start), int'(m_start));
            chk("left", int'(left), int'(m_left));
            chk("right", int'(right), int'(m_right));
            chk("shoot", int'(shoot), int'(m_shoot));
            chk("shoot_ready", int'(shoot_ready), int'(m_ready));
        end
    end

    // Strobe log: the edge index after which each strobe was seen.
    int start_q[$], left_q[$], right_q[$], shoot_q[$];
    int ready_low = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (start === 1'b1) start_q.push_back(cyc);
                if (left === 1'b1) left_q.push_back(cyc);
                if (right === 1'b1) right_q.push_back(cyc);
                if (shoot === 1'b1) shoot_q.push_back(cyc);
                if (shoot_ready === 1'b0) ready_low++;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk_edge(input string name, input int q[$], input int idx, input int exp);
        if (q.size() > idx) chk(name, q[idx], exp);
        else chk({name, "_missing"}, q.size(), idx + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int t0, t1, t2, n0, n1, r0, s0;

    initial begin
        // 1. reset values
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        wait_cyc(50);
        chk("reset_no_strobes", start_q.size() + left_q.size() + right_q.size() + shoot_q.size(), 0);
        chk("reset_ready", int'(shoot_ready), 1);

        // 2a. start with play=0: strobe after edge 7
        t0 = cyc; n0 = start_q.size();
        btn_start = 1'b1;
        wait_cyc(20);
        btn_start = 1'b0;
        wait_cyc(20);
        chk("start_count", start_q.size() - n0, 1);
        chk_edge("start_edge", start_q, n0, t0 + 7);

        // 2b. 3-cycle glitch: no strobe
        n0 = start_q.size();
        btn_start = 1'b1;
        wait_cyc(3);
        btn_start = 1'b0;
        wait_cyc(20);
        chk("glitch_no_start", start_q.size() - n0, 0);

        // 2c. start while playing: discarded
        play = 1'b1;
        n0 = start_q.size();
        btn_start = 1'b1;
        wait_cyc(20);
        btn_start = 1'b0;
        wait_cyc(20);
        chk("start_in_play", start_q.size() - n0, 0);

        // 3. auto-repeat then conflict
        t0 = cyc; n0 = left_q.size(); r0 = right_q.size();
        btn_left = 1'b1;
        wait_cyc(40);
        chk("left_repeat_count", left_q.size() - n0, 5);
        chk_edge("left_first", left_q, n0, t0 + 7);
        chk_edge("left_fifth", left_q, n0 + 4, t0 + 39);
        t1 = cyc; n1 = left_q.size();
        btn_right = 1'b1;
        wait_cyc(20);
        t2 = cyc;
        btn_left = 1'b0;
        wait_cyc(30);
        btn_right = 1'b0;
        wait_cyc(20);
        chk("conflict_no_left", left_q.size() - n1, 0);
        chk("right_count", right_q.size() - r0, 4);
        chk_edge("right_first", right_q, r0, t2 + 8);

        // 4. shoot cooldown
        t0 = cyc; s0 = shoot_q.size(); n0 = ready_low;
        btn_shoot = 1'b1;
        wait_cyc(10);
        btn_shoot = 1'b0;
        wait_cyc(12);
        btn_shoot = 1'b1;
        wait_cyc(10);
        btn_shoot = 1'b0;
        wait_cyc(18);
        chk("shoot_once", shoot_q.size() - s0, 1);
        chk_edge("shoot_edge", shoot_q, s0, t0 + 7);
        chk("ready_low_len", ready_low - n0, CD);
        wait_cyc(5);
        t1 = cyc;
        btn_shoot = 1'b1;
        wait_cyc(10);
        btn_shoot = 1'b0;
        wait_cyc(40);
        chk("shoot_again", shoot_q.size() - s0, 2);
        chk_edge("shoot_again_edge", shoot_q, s0 + 1, t1 + 7);

        // 5. play drop during hold and cooldown
        t0 = cyc; n0 = left_q.size(); s0 = shoot_q.size();
        btn_left = 1'b1;
        btn_shoot = 1'b1;
        wait_cyc(12);
        chk_edge("simul_left", left_q, n0, t0 + 7);
        chk_edge("simul_shoot", shoot_q, s0, t0 + 7);
        chk("ready_before_drop", int'(shoot_ready), 0);
        play = 1'b0;
        n1 = left_q.size(); s0 = shoot_q.size();
        wait_cyc(1);
        chk("ready_after_drop", int'(shoot_ready), 1);
        wait_cyc(20);
        chk("drop_no_left", left_q.size() - n1, 0);
        chk("drop_no_shoot", shoot_q.size() - s0, 0);
        btn_left = 1'b0;
        btn_shoot = 1'b0;
        wait_cyc(20);
        play = 1'b1;
        wait_cyc(5);

        // 6. reset while left is held
        t0 = cyc; n0 = left_q.size();
        btn_left = 1'b1;
        wait_cyc(20);
        chk("pre_reset_left", left_q.size() - n0, 2);
        rst_n = 1'b0;
        #1;
        chk("reset_ready_now", int'(shoot_ready), 1);
        chk("reset_left_now", int'(left), 0);
        wait_cyc(2);
        rst_n = 1'b1;
        t1 = cyc; n1 = left_q.size();
        wait_cyc(15);
        chk_edge("post_reset_left", left_q, n1, t1 + 7);
        btn_left = 1'b0;
        wait_cyc(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/player_input_ctrl.md
Name: player_input_ctrl

Overview:
- Front-end that conditions raw board buttons into the clean, single-cycle command strobes the game-state and player-motion logic consume: `start`, `left`, `right`, `shoot`.
- Sits between the board pins and the top-level game core, driving the same `start`, `left`, `right` and `shoot` nets.
- Provides synchronisation, debouncing, edge detection, held-direction auto-repeat and shot cooldown.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a debounced level changes (min 1).
- REPEAT_CYCLES, 8: cycle period between auto-repeat move strobes while a direction is held (min 1).
- SHOOT_COOLDOWN, 32: cycles after a shot strobe during which further shots are rejected (min 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_start  in  1  raw start button, asynchronous, active-high.
- btn_left  in  1  raw left button, asynchronous, active-high.
- btn_right  in  1  raw right button, asynchronous, active-high.
- btn_shoot  in  1  raw fire button, asynchronous, active-high.
- play  in  1  game-core flag: 1 = game in progress.
- start  out  1  one-cycle start strobe.
- left  out  1  one-cycle move-left strobe.
- right  out  1  one-cycle move-right strobe.
- shoot  out  1  one-cycle fire strobe.
- shoot_ready  out  1  1 when the cooldown counter is zero.

Behaviour:
- **Reset** (reset=0, async): all sync flops, debounced levels, counters, and `start`/`left`/`right`/`shoot` clear to 0. `shoot_ready`=1. All outputs are registered.
- **Synchronizer:** each button passes through a 2-flop synchronizer (s1→s2).
- **Debouncer, per button:**
  - Counter width = clog2(DEBOUNCE_CYCLES+1); stable level `db`.
  - If s2==db, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, db<=s2 and the counter clears at that same edge.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes db.
- **Edge detect:** press = db rising (db=1 and db_prev=0).
- **Latency:**
  - Raw level first sampled at edge 1, into s1.
  - db changes at edge DEBOUNCE_CYCLES+2.
  - The strobe is high for exactly one cycle following edge DEBOUNCE_CYCLES+3.
- **start:** strobe on start press only when play=0. A press while play=1 is discarded, not queued.
- **Direction FSM**, states IDLE, HOLD_L, HOLD_R, CONFLICT:
  - IDLE: db_left=1 and db_right=0 → strobe `left`, load repeat counter with REPEAT_CYCLES-1, go to HOLD_L. HOLD_R is symmetric for the right button. Both 1 → CONFLICT, no strobe.
  - HOLD_x: counter decrements each cycle. On 0, strobe `x` and reload REPEAT_CYCLES-1. The held-strobe period is therefore exactly REPEAT_CYCLES cycles.
  - HOLD_x, held button released → IDLE, no strobe.
  - HOLD_x, opposite button also becomes 1 → CONFLICT, no strobe.
  - CONFLICT: stay until exactly one or neither button is held; go to IDLE. The next cycle then follows the IDLE rules, so the first strobe is issued 1 cycle after leaving CONFLICT.
  - `left` and `right` are never asserted in the same cycle.
  - The FSM only advances while play=1. If play=0, FSM → IDLE, counter → 0, no strobes.
- **Shoot and cooldown:**
  - A shoot press with play=1 and cooldown=0 → strobe `shoot`, cooldown <= SHOOT_COOLDOWN.
  - cooldown decrements each cycle while >0, so `shoot_ready` returns to 1 exactly SHOOT_COOLDOWN cycles after the strobe edge.
  - A press while cooldown>0 is dropped, not queued.
  - Holding the fire button fires once only; a new press edge is required.
  - play=0 forces cooldown to 0.
- **Simultaneous events:** `start`, a direction strobe and `shoot` may assert in the same cycle. Each path is independent.
- **Reset mid-operation:** takes effect immediately. After release, a button held across reset produces a press once db rises, i.e. DEBOUNCE_CYCLES+3 edges after reset release.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, SHOOT_COOLDOWN=32):
1. **Reset values:** reset=0 at t=0, released at edge 2, buttons low → all strobes 0 and shoot_ready=1 for 50 cycles.
2. **Start and debounce:**
   - play=0, btn_start held high → `start` high for exactly one cycle, after edge 7 counted from the first sampling edge.
   - A 3-cycle btn_start pulse → no strobe.
   - btn_start held with play=1 → no strobe.
3. **Auto-repeat and conflict:**
   - play=1, btn_left held 40 cycles → first `left` after edge 7, then 4 more strobes spaced 8 cycles apart. `right` stays 0.
   - Adding btn_right mid-hold → strobes stop. Releasing btn_left → `right` strobes resume after debounce.
4. **Shoot cooldown:**
   - play=1, btn_shoot pressed → one `shoot`, shoot_ready=0 for 32 cycles.
   - Re-press at cooldown 10 → no strobe.
   - Re-press after shoot_ready=1 → new `shoot`.
5. **play drop:** play=1, left held in HOLD_L, shoot on cooldown; drop play → no strobes, shoot_ready=1 on the next cycle.
6. **Mid-hold reset:** pulse reset low while btn_left is held → outputs clear immediately. After release, `left` reappears DEBOUNCE_CYCLES+3 edges later (play=1).
